gecko_xor: RTL and testbench
============================

// Module: gecko_xor
// PURPOSE
//  Decrypts a byte stream by XORing each ciphertext byte with the next byte from the
//  gecko keystream generator. It sits directly downstream of gecko: it drives gecko's
//  `next`, and it samples `dout`/`ready`.
//  A small prefetch FIFO hides gecko's 8-clken-per-byte latency. A seek command
//  discards keystream bytes so decryption can start at a stream offset.
//  An all-zero key gives a zero keystream, so ciphertext passes through unchanged.
// PARAMETERS
//  KS_DEPTH  4   keystream prefetch FIFO entries; power of 2, >=2
//  SEEK_W    16  width of seek_len and skip counter
//  CNT_W     24  width of byte_count; wraps modulo 2^CNT_W
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       async reset, active low
//  clken       in   1       same clock enable that drives gecko
//  ks_ready    in   1       gecko ready: ks_byte is valid
//  ks_byte     in   8       gecko dout
//  ks_next     out  1       gecko next: consume the current keystream byte
//  din         in   8       ciphertext byte
//  din_valid   in   1       din is valid
//  din_ready   out  1       din is accepted on this clk
//  dout        out  8       plaintext byte (registered)
//  dout_valid  out  1       dout is valid
//  dout_ready  in   1       downstream accepts dout
//  seek_valid  in   1       one-clk request to skip seek_len keystream bytes
//  seek_len    in   SEEK_W  number of keystream bytes to discard
//  seek_busy   out  1       high while a skip is in progress (state SKIP)
//  byte_count  out  CNT_W   keystream bytes consumed so far (XORed or skipped)
// BEHAVIOUR
//  Reset values: dout=0, dout_valid=0, seek_busy=0, byte_count=0, FIFO empty,
//  skip_left=0, state=RUN. A reset mid-operation abandons any skip or transfer.
//  Fetch (combinational ks_next):
//   RUN:  ks_next = ks_ready & ~fifo_full.
//   SKIP: ks_next = ks_ready & fifo_empty.
//  Capture happens on a clk edge where clken & ks_next. In RUN the block pushes ks_byte.
//  In SKIP it discards ks_byte. gecko drops ready on that same edge, so at most one byte
//  is taken per gecko WAIT. ks_next may be high with clken low; nothing is captured.
//  Cipher path (RUN only):
//   din_ready = ~fifo_empty & (~dout_valid | dout_ready).
//   On din_valid & din_ready: dout <= din ^ fifo_head; pop; dout_valid <= 1; byte_count++.
//   Else if dout_ready: dout_valid <= 0.
//   Zero-bubble throughput when the FIFO is non-empty.
//  FIFO: a push and a pop on the same clk is legal; occupancy stays the same. Order is
//  strictly preserved. A push while full cannot occur (ks_next is gated).
//  FSM RUN/SKIP:
//   RUN -> SKIP: seek_valid & seek_len!=0. Load skip_left=seek_len. din_ready=0 in SKIP.
//     On that transfer clk, din_ready is forced low. Any pending dout still drains.
//   seek_valid with seek_len=0, or asserted while in SKIP: ignored.
//   SKIP, each clk: if FIFO non-empty, pop one entry. Else, on a capture, discard ks_byte.
//     Each discard does skip_left--, byte_count++. At most one per clk.
//   SKIP -> RUN: on the clk where skip_left goes from 1 to 0. seek_busy = (state==SKIP).
//  byte_count wraps from 2^CNT_W-1 to 0 silently.
// STRUCTURE
//  gecko_pkg: state localparams (ST_RUN, ST_SKIP) and KS_W=8.
//  Sub-module ks_fifo: sync FIFO with KS_DEPTH x 8 registers, rd/wr pointers with extra
//  wrap bit, and full/empty flags. The top level holds the FSM, the XOR/output register
//  and the counters.
// TESTING (gecko replaced by a behavioural model that serves a known byte list,
//  using ready/next with clken)
//  1 Keystream 5A,3C,81. din 00,FF,81 with dout_ready=1 -> dout 5A,C3,00; byte_count=3.
//  2 dout_ready=0 for 20 clk -> FIFO holds 4 bytes, ks_next stays 0 while full; on release
//    the outputs match the keystream in order with no loss or duplication.
//  3 Zero-key model (ks_byte=00) -> 16 random din bytes appear unchanged on dout.
//  4 With 4 bytes prefetched, seek_len=6 -> 4 pops plus 2 discards, seek_busy high
//    ~6+ clk. The next dout uses keystream byte #7; byte_count=6.
//  5 clken toggling 1-of-3 clk -> exactly one capture per ks_ready pulse; results as in 1.
//  6 rst_n low in the middle of a seek -> outputs at reset values at once; after release,
//    state RUN and the FIFO is empty.

Source files
------------

// File: rtl/gecko_pkg.sv
// Shared types and constants for the gecko keystream XOR decryptor.
package gecko_pkg;

  // Keystream and data byte width.
  localparam int KS_W = 8;

  // Top-level operating state: normal decryption or keystream skipping.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

endpackage

// File: rtl/ks_fifo.sv
// Keystream prefetch FIFO: DEPTH x KS_W registers, pointers with an extra wrap bit.
module ks_fifo
  import gecko_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [KS_W-1:0] push_data,
  input  logic            pop,
  output logic [KS_W-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [KS_W-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  // Write the pushed keystream byte into the slot addressed by the write pointer.
  // NOTE: the storage array has no reset; validity comes only from the pointers,
  // so clearing the data would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Advance read/write pointers; push and pop may happen on the same clk.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/gecko_xor.sv
// Decrypts a byte stream by XORing each ciphertext byte with the next gecko
// keystream byte. A prefetch FIFO hides gecko latency; a seek discards bytes.
module gecko_xor
  import gecko_pkg::*;
#(
  parameter int KS_DEPTH = 4,
  parameter int SEEK_W   = 16,
  parameter int CNT_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clken,
  input  logic              ks_ready,
  input  logic [KS_W-1:0]   ks_byte,
  output logic              ks_next,
  input  logic [KS_W-1:0]   din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [KS_W-1:0]   dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  input  logic              seek_valid,
  input  logic [SEEK_W-1:0] seek_len,
  output logic              seek_busy,
  output logic [CNT_W-1:0]  byte_count
);

  localparam logic [SEEK_W-1:0] SKIP_ONE = {{(SEEK_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [SEEK_W-1:0] skip_left;

  logic              fifo_full;
  logic              fifo_empty;
  logic [KS_W-1:0]   fifo_head;

  logic              capture;
  logic              push;
  logic              pop;
  logic              start_seek;
  logic              fire;
  logic              skip_pop;
  logic              skip_discard;
  logic              skip_step;

  // A keystream byte is taken only on an enabled edge; gecko drops ready on it.
  assign capture      = clken & ks_next;
  assign push         = capture & (state == ST_RUN);
  assign start_seek   = (state == ST_RUN) & seek_valid & (seek_len != '0);
  assign fire         = din_valid & din_ready;
  // While skipping, prefetched bytes are drained first, then fresh ones discarded.
  assign skip_pop     = (state == ST_SKIP) & ~fifo_empty;
  assign skip_discard = (state == ST_SKIP) & fifo_empty & capture;
  assign skip_step    = skip_pop | skip_discard;
  assign pop          = fire | skip_pop;

  ks_fifo #(
    .DEPTH (KS_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ks_byte),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // FSM next state: enter SKIP on a non-zero seek, leave on the last skipped byte.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (start_seek) state_nxt = ST_SKIP;
      ST_SKIP: if (skip_step && (skip_left == SKIP_ONE)) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: keystream fetch, input handshake and busy flag per state.
  always_comb begin
    ks_next   = 1'b0;
    din_ready = 1'b0;
    seek_busy = 1'b0;
    case (state)
      ST_RUN: begin
        ks_next   = ks_ready & ~fifo_full;
        din_ready = ~fifo_empty & (~dout_valid | dout_ready) & ~start_seek;
      end
      ST_SKIP: begin
        ks_next   = ks_ready & fifo_empty;
        seek_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Remaining bytes to skip: loaded on seek start, decremented per discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          skip_left <= '0;
    else if (start_seek) skip_left <= seek_len;
    else if (skip_step)  skip_left <= skip_left - SKIP_ONE;
  end

  // Output register: XOR on transfer, otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (fire) begin
      dout       <= din ^ fifo_head;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Count every keystream byte consumed, XORed or skipped; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 byte_count <= '0;
    else if (fire || skip_step) byte_count <= byte_count + CNT_ONE;
  end

endmodule

// File: tb/tb_gecko_xor.sv
// Self-checking bench for gecko_xor with a behavioural gecko keystream source.
module tb_gecko_xor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clken = 1'b1;
  logic        ks_ready;
  logic [7:0]  ks_byte;
  logic        ks_next;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        seek_valid = 1'b0;
  logic [15:0] seek_len = 16'h0000;
  logic        seek_busy;
  logic [23:0] byte_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Keystream served by the gecko model, one byte per ready pulse.
  logic [7:0] ks_mem [256];
  int         ks_idx;
  int         gen;
  int         clk_mode = 0;
  int         div = 0;

  // Reference: position in the keystream and expected/observed output streams.
  int         pos;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  gecko_xor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clken      (clken),
    .ks_ready   (ks_ready),
    .ks_byte    (ks_byte),
    .ks_next    (ks_next),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .seek_valid (seek_valid),
    .seek_len   (seek_len),
    .seek_busy  (seek_busy),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Clock enable: every clk, or one clk in three.
  always @(posedge clk) begin
    #1;
    div   = (div + 1) % 3;
    clken = (clk_mode == 0) || (div == 0);
  end

  // Gecko model: 8 enabled clks to produce a byte, hold ready until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_ready <= 1'b0;
      gen      <= 0;
      ks_idx   <= 0;
    end else if (clken) begin
      if (ks_ready) begin
        if (ks_next) begin
          ks_ready <= 1'b0;
          ks_idx   <= ks_idx + 1;
        end
      end else if (gen == 7) begin
        ks_ready <= 1'b1;
        gen      <= 0;
      end else begin
        gen <= gen + 1;
      end
    end
  end

  assign ks_byte = ks_mem[ks_idx[7:0]];

  // Reference model: each accepted byte uses the next keystream position, a seek skips ahead.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0;
      exp_q.delete();
      got_q.delete();
    end else begin
      if (dout_valid && dout_ready) got_q.push_back(dout);
      if (din_valid && din_ready) begin
        exp_q.push_back(din ^ ks_mem[pos[7:0]]);
        pos++;
      end
      if (seek_valid && (seek_len != 16'h0000) && !seek_busy) pos += int'(seek_len);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din        = 8'h00;
    seek_valid = 1'b0;
    seek_len   = 16'h0000;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dout",       32'(dout),       32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_seek_busy",  32'(seek_busy),  32'h0);
    check("rst_byte_count", 32'(byte_count), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", 32'(t < 500), 32'h1);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic wait_full();
    int t = 0;
    @(negedge clk);
    while (!(ks_ready && !ks_next && !seek_busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("full_timeout", 32'(t < 400), 32'h1);
  endtask

  task automatic drain();
    int t = 0;
    dout_ready = 1'b1;
    @(negedge clk);
    while ((dout_valid || got_q.size() != exp_q.size()) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(t < 300), 32'h1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++) ks_mem[i] = 8'(i * 37 + 11);
  endtask

  initial begin
    automatic logic [7:0] sent[$];
    automatic int viol;
    automatic int busy_cnt;
    automatic int t;

    // 1: basic decryption with a known keystream.
    fill_pattern();
    ks_mem[0] = 8'h5A; ks_mem[1] = 8'h3C; ks_mem[2] = 8'h81;
    do_reset();
    send(8'h00); send(8'hFF); send(8'h81);
    drain();
    check("t1_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("t1_b0", 32'(got_q[0]), 32'h5A);
      check("t1_b1", 32'(got_q[1]), 32'hC3);
      check("t1_b2", 32'(got_q[2]), 32'h00);
    end
    check("t1_count", 32'(byte_count), 32'd3);

    // 2: downstream stall fills the FIFO; ks_next held low while full.
    for (int i = 0; i < 256; i++) ks_mem[i] = 8'($urandom);
    do_reset();
    dout_ready = 1'b0;
    send(8'h11);
    din       = 8'h22;
    din_valid = 1'b1;
    wait_full();
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ks_next || din_ready) viol++;
    end
    check("t2_stall_held", 32'(viol), 32'd0);
    check("t2_count_stall", 32'(byte_count), 32'd1);
    @(posedge clk);
    #1 dout_ready = 1'b1;
    send(8'h22);
    for (int i = 0; i < 6; i++) send(8'($urandom));
    drain();
    check("t2_total", 32'(got_q.size()), 32'd8);
    check_stream("t2");
    check("t2_count", 32'(byte_count), 32'(pos));

    // 3: zero key passes ciphertext through unchanged.
    for (int i = 0; i < 256; i++) ks_mem[i] = 8'h00;
    do_reset();
    sent.delete();
    for (int i = 0; i < 16; i++) begin
      automatic logic [7:0] b = 8'($urandom);
      sent.push_back(b);
      send(b);
      if ($urandom_range(0, 2) == 0) begin
        dout_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    end
    drain();
    check("t3_len", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check("t3_passthru", 32'(got_q[i]), 32'(sent[i]));
    check("t3_count", 32'(byte_count), 32'd16);

    // 4: seek of 6 with 4 bytes prefetched; ignored seeks in SKIP and of length 0.
    fill_pattern();
    do_reset();
    wait_full();
    check("t4_count_pre", 32'(byte_count), 32'd0);
    @(posedge clk);
    #1 seek_len = 16'd6; seek_valid = 1'b1;
    @(posedge clk);
    #1 seek_len = 16'd50;
    @(negedge clk);
    check("t4_busy_on", 32'(seek_busy), 32'h1);
    busy_cnt = 1;
    @(posedge clk);
    #1 seek_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (seek_busy && t < 300) begin
      busy_cnt++;
      @(negedge clk);
      t++;
    end
    check("t4_busy_timeout", 32'(t < 300), 32'h1);
    check("t4_busy_len", 32'(busy_cnt >= 6), 32'h1);
    check("t4_count_seek", 32'(byte_count), 32'd6);
    send(8'h00);
    drain();
    check("t4_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t4_ks7", 32'(got_q[0]), 32'hE9);
    @(posedge clk);
    #1 seek_len = 16'd0; seek_valid = 1'b1;
    @(posedge clk);
    #1 seek_valid = 1'b0;
    @(negedge clk);
    check("t4_zero_seek", 32'(seek_busy), 32'h0);
    check("t4_count_end", 32'(byte_count), 32'd7);

    // 5: clken one clk in three, same results as the basic case.
    clk_mode = 1;
    fill_pattern();
    ks_mem[0] = 8'h5A; ks_mem[1] = 8'h3C; ks_mem[2] = 8'h81;
    do_reset();
    send(8'h00); send(8'hFF); send(8'h81);
    drain();
    check("t5_len", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("t5_b0", 32'(got_q[0]), 32'h5A);
      check("t5_b1", 32'(got_q[1]), 32'hC3);
      check("t5_b2", 32'(got_q[2]), 32'h00);
    end
    check("t5_count", 32'(byte_count), 32'd3);
    clk_mode = 0;

    // 6: reset in the middle of a seek.
    fill_pattern();
    do_reset();
    send(8'hA5);
    wait_full();
    @(posedge clk);
    #1 seek_len = 16'd20; seek_valid = 1'b1;
    @(posedge clk);
    #1 seek_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_busy_mid", 32'(seek_busy), 32'h1);
    check("t6_dout_pre", 32'(dout), 32'hAE);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_dout",  32'(dout),       32'h0);
    check("t6_rst_valid", 32'(dout_valid), 32'h0);
    check("t6_rst_busy",  32'(seek_busy),  32'h0);
    check("t6_rst_count", 32'(byte_count), 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1; din = 8'h77; din_valid = 1'b1;
    @(negedge clk);
    check("t6_run_after", 32'(seek_busy), 32'h0);
    check("t6_fifo_empty", 32'(din_ready), 32'h0);
    send(8'h77);
    drain();
    check("t6_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t6_first", 32'(got_q[0]), 32'h7C);
    check("t6_count", 32'(byte_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
